stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 101 ++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: one input stream routed to one of three output channels, or discarded,
// as selected by demux_ctrl when the beat is accepted. Each channel has a single
// holding register; a stalled channel only backpressures beats addressed to it.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_data    upstream handshake and payload
//   demux_ctrl                   0,1,2 = destination channel, 3 = discard
//   out_valid_k/out_ready_k/out_data_k (k=0..2)  downstream channel handshakes
//   drop_cnt                     saturating count of discarded beats
module stream_demux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        demux_ctrl,
   output logic              out_valid_0,
   output logic              out_valid_1,
   output logic              out_valid_2,
   input  logic              out_ready_0,
   input  logic              out_ready_1,
   input  logic              out_ready_2,
   output logic [DATA_W-1:0] out_data_0,
   output logic [DATA_W-1:0] out_data_1,
   output logic [DATA_W-1:0] out_data_2,
   output logic [CNT_W-1:0]  drop_cnt
);

   logic [2:0]        valid_q;
   logic [2:0]        valid_d;
   logic [DATA_W-1:0] data_q [3];
   logic [DATA_W-1:0] data_d [3];
   logic [CNT_W-1:0]  drop_q;
   logic [CNT_W-1:0]  drop_d;
   logic [2:0]        ready_vec;
   logic [2:0]        load;
   logic              sel_busy;
   logic              accept;

   assign ready_vec = {out_ready_2, out_ready_1, out_ready_0};

   // Selected channel is blocked only when it is full and its consumer is stalled;
   // discard is never blocked.
   always_comb begin
      sel_busy = 1'b0;
      case (demux_ctrl)
         2'd0:    sel_busy = valid_q[0] & ~ready_vec[0];
         2'd1:    sel_busy = valid_q[1] & ~ready_vec[1];
         2'd2:    sel_busy = valid_q[2] & ~ready_vec[2];
         default: sel_busy = 1'b0;
      endcase
      in_ready = ~rst & ~sel_busy;
   end

   assign accept = in_valid & in_ready;

   // Load takes priority over drain so a simultaneous drain+load keeps the channel full.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         load[k]    = accept & (demux_ctrl == 2'(k));
         valid_d[k] = load[k] | (valid_q[k] & ~ready_vec[k]);
         data_d[k]  = load[k] ? in_data : data_q[k];
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (accept && (demux_ctrl == 2'd3) && (drop_q != {CNT_W{1'b1}})) begin
         drop_d = drop_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < 3; k++) begin
            data_q[k] <= '0;
         end
         drop_q <= '0;
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < 3; k++) begin
            data_q[k] <= data_d[k];
         end
         drop_q <= drop_d;
      end
   end

   assign out_valid_0 = valid_q[0];
   assign out_valid_1 = valid_q[1];
   assign out_valid_2 = valid_q[2];
   assign out_data_0  = data_q[0];
   assign out_data_1  = data_q[1];
   assign out_data_2  = data_q[2];
   assign drop_cnt    = drop_q;

endmodule
